// File: rtl/janela_pkg.sv
// Shared types and default sizes for the 3x3 binary window generator.
package janela_pkg;

  localparam int unsigned LarguraPadrao = 8;
  localparam int unsigned AlturaPadrao  = 8;

  typedef enum logic [1:0] {
    StOcioso = 2'd0,
    StEnche  = 2'd1,
    StAtivo  = 2'd2,
    StFim    = 2'd3
  } estado_t;

endpackage

// File: rtl/linha_buffer.sv
// One image row of binary pixels; combinational read, so a read and a write
// at the same address in one cycle return the old bit.
module linha_buffer #(
  parameter int unsigned LARGURA = 8
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(LARGURA)-1:0] addr,
  input  logic                       din,
  output logic                       dout
);

  logic [LARGURA-1:0] mem_q;

  assign dout = mem_q[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= din;
    end
  end

endmodule

// File: rtl/gera_janela.sv
// Streams a binary raster image and emits 3x3 windows from two line buffers.
// Optional status outputs (frame_done, erro) under GERA_JANELA_STATUS_EN.
module gera_janela
  import janela_pkg::*;
#(
  parameter int unsigned LARGURA = LarguraPadrao,
  parameter int unsigned ALTURA  = AlturaPadrao
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_in,
  input  logic       pix_valid,
  input  logic       sof,
  output logic [2:0] q1,
  output logic [2:0] q2,
  output logic [2:0] q3,
  output logic       win_valid
`ifdef GERA_JANELA_STATUS_EN
  ,
  output logic       frame_done,
  output logic       erro
`endif
);

  localparam int unsigned CW = $clog2(LARGURA);
  localparam int unsigned RW = $clog2(ALTURA);
  localparam logic [CW-1:0] ColMax = CW'(LARGURA - 1);
  localparam logic [RW-1:0] LinMax = RW'(ALTURA - 1);

  estado_t       estado_q, estado_d;
  logic [CW-1:0] col_q, col_d, col_cur;
  logic [RW-1:0] lin_q, lin_d, lin_cur;
  logic          inicio, aceita, ultima_col, ultimo_pix, win_d;
  logic          lb0_rd, lb1_rd;

  always_comb begin
    inicio     = pix_valid & sof;
    aceita     = inicio | (pix_valid & ((estado_q == StEnche) | (estado_q == StAtivo)));
    // A sof pixel is always (0,0), whatever the counters say.
    col_cur    = inicio ? '0 : col_q;
    lin_cur    = inicio ? '0 : lin_q;
    ultima_col = (col_cur == ColMax);
    ultimo_pix = ultima_col & (lin_cur == LinMax);
    win_d      = aceita & ~inicio & (lin_cur >= RW'(2)) & (col_cur >= CW'(2));

    col_d    = col_q;
    lin_d    = lin_q;
    estado_d = estado_q;

    if (aceita) begin
      if (ultima_col) begin
        col_d = '0;
        lin_d = (lin_cur == LinMax) ? '0 : lin_cur + RW'(1);
      end else begin
        col_d = col_cur + CW'(1);
        lin_d = lin_cur;
      end
    end

    unique case (estado_q)
      StOcioso, StFim: begin
        if (inicio) estado_d = StEnche;
      end
      StEnche: begin
        if (inicio) estado_d = StEnche;
        else if (aceita && ultima_col && (lin_cur == RW'(1))) estado_d = StAtivo;
      end
      StAtivo: begin
        if (inicio) estado_d = StEnche;
        else if (aceita && ultimo_pix) estado_d = StFim;
      end
      default: estado_d = StOcioso;
    endcase
  end

  linha_buffer #(
    .LARGURA(LARGURA)
  ) u_lb0 (
    .clk (clk),
    .we  (aceita),
    .addr(col_cur),
    .din (pix_in),
    .dout(lb0_rd)
  );

  linha_buffer #(
    .LARGURA(LARGURA)
  ) u_lb1 (
    .clk (clk),
    .we  (aceita),
    .addr(col_cur),
    .din (lb0_rd),
    .dout(lb1_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q  <= StOcioso;
      col_q     <= '0;
      lin_q     <= '0;
      q1        <= 3'b000;
      q2        <= 3'b000;
      q3        <= 3'b000;
      win_valid <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      col_q     <= col_d;
      lin_q     <= lin_d;
      win_valid <= win_d;
      if (aceita) begin
        q3 <= {q3[1:0], pix_in};
        q2 <= {q2[1:0], lb0_rd};
        q1 <= {q1[1:0], lb1_rd};
      end
    end
  end

`ifdef GERA_JANELA_STATUS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done <= 1'b0;
      erro       <= 1'b0;
    end else begin
      frame_done <= aceita & ~inicio & (estado_q == StAtivo) & ultimo_pix;
      if (inicio) begin
        erro <= 1'b0;
      end else if ((estado_q == StFim) && pix_valid) begin
        erro <= 1'b1;
      end
    end
  end
`endif

endmodule
